multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle sequencer for the mini-CPU datapath.
//  - Splits every instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives the existing datapath strobes one step per clock.
//  - Waits on a RAM ready handshake and traps on illegal opcodes or memory timeouts.
//  - Sits between the instruction register / RAM and the PC, regfile and ALU controls.
// PARAMETERS
//  TIMEOUT    15  max wait cycles in FETCH/MEM without mem_ready before trapping
//  TIMEOUT_W  4   width of wait counter (must hold TIMEOUT)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  main_op    in   3  opcode from IR (valid from DECODE onward)
//  alu_in     in   4  R-type funct from IR
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  RAM access complete this cycle
//  alu_out    out  3  ALU operation select
//  alusrc     out  2  ALU B source: 0 reg, 1 immediate, 2/3 unused
//  en_pc      out  1  PC update strobe (one cycle per instruction)
//  jump       out  1  PC <- jump target (with en_pc)
//  pcsrc      out  1  0 PC+1, 1 branch target (with en_pc)
//  we_reg     out  1  regfile write strobe
//  en_ram     out  1  RAM access request
//  we_ram     out  1  RAM write (only with en_ram)
//  wrtsrc     out  1  regfile data: 0 ALU, 1 RAM
//  rdsrc      out  1  RAM address: 0 PC, 1 ALU result
//  ir_we      out  1  IR load strobe
//  halted     out  1  sticky, HALT executed
//  trap       out  1  sticky, illegal instruction or timeout
//  state      out  3  current state code (debug)
// BEHAVIOUR
//  - Opcodes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 JMP, 7 HALT.
//  - ALU codes: R funct 0..5 -> alu_out=funct (ADD,SUB,AND,OR,XOR,SLT). ADDI/LW/SW -> 0. BEQ/BNE -> 1.
//  - States: INIT=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 TRAP=7.
//  - Outputs are Moore/Mealy decode of the registered state and op; they are 0 unless listed below.
//  - Reset (async, any state): state=INIT, all outputs 0, op/funct regs and wait counter cleared. INIT -> FETCH next clock.
//  - FETCH: en_ram=1, rdsrc=0. On mem_ready: ir_we=1 the same cycle, then -> DECODE.
//  - DECODE: latch main_op/alu_in into op_q/fn_q. Then:
//    - op 7 -> HALT.
//    - op 0 with funct>5 -> TRAP.
//    - op 6: en_pc=1, jump=1, -> FETCH.
//    - otherwise -> EXEC.
//  - EXEC: alu_out per op_q. alusrc=1 for ADDI/LW/SW, else 0. Then:
//    - BEQ/BNE: en_pc=1, pcsrc=(BEQ&zero)|(BNE&~zero), -> FETCH.
//    - R/ADDI -> WB.
//    - LW/SW -> MEM.
//  - MEM: en_ram=1, rdsrc=1, we_ram=(op_q==SW), alusrc=1, alu_out=0 held. On mem_ready:
//    - SW: en_pc=1, -> FETCH.
//    - LW: -> WB.
//  - WB: we_reg=1, wrtsrc=(op_q==LW), alu_out/alusrc held from EXEC, en_pc=1, pcsrc=0, -> FETCH.
//  - Wait counter:
//    - Cleared on entry to FETCH/MEM; +1 per cycle there without mem_ready.
//    - Reaching TIMEOUT without ready -> TRAP.
//    - mem_ready in the cycle the count reaches TIMEOUT wins (normal advance).
//  - mem_ready is ignored outside FETCH/MEM. zero is sampled only in EXEC.
//  - HALT/TRAP: terminal, all strobes 0, halted/trap=1; exit only via rst_n.
//  - Latency with zero-wait RAM: R/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE 3, JMP 2 (FETCH through PC update).
// TESTING
//  - Reset release: rst_n low -> all outputs 0, state=0. Release -> state 1 next clock with en_ram=1, rdsrc=0.
//  - R-type funct=3, mem_ready high 2 cycles after FETCH entry:
//    - FETCH held 3 cycles; ir_we pulses once.
//    - EXEC: alu_out=3, alusrc=0.
//    - WB: we_reg=1, wrtsrc=0, en_pc=1. Exactly one en_pc pulse.
//  - LW then SW, ready after 1 wait:
//    - LW: MEM rdsrc=1, we_ram=0, then WB with wrtsrc=1.
//    - SW: we_ram=1 only in MEM, we_reg never set, en_pc on ready.
//  - BEQ zero=1 -> en_pc=1, pcsrc=1. BNE zero=1 -> pcsrc=0. JMP -> jump=1 in DECODE, no EXEC.
//  - op 7 -> halted=1 sticky, no strobes for 20 cycles. R funct=9 -> trap=1.
//    TIMEOUT=3, mem_ready held low -> trap after 3 FETCH wait cycles.
//  - rst_n pulled low mid-MEM with we_ram=1 -> we_ram/en_ram drop immediately. Restart from INIT->FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the mini-CPU: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes, with RAM wait handling and traps.
module multicycle_controller #(
  parameter int TIMEOUT   = 15,
  parameter int TIMEOUT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] main_op,
  input  logic [3:0] alu_in,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_out,
  output logic [1:0] alusrc,
  output logic       en_pc,
  output logic       jump,
  output logic       pcsrc,
  output logic       we_reg,
  output logic       en_ram,
  output logic       we_ram,
  output logic       wrtsrc,
  output logic       rdsrc,
  output logic       ir_we,
  output logic       halted,
  output logic       trap,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_BNE  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t               state_q, state_d;
  logic [2:0]           op_q;
  logic [2:0]           fn_q;  // funct > 5 traps in DECODE, so three bits suffice
  logic [TIMEOUT_W-1:0] wait_q;
  logic                 timed_out;

  assign timed_out = (wait_q == TIMEOUT_W'(TIMEOUT));
  assign state     = state_q;

  function automatic logic [2:0] alu_code(input logic [2:0] op, input logic [2:0] fn);
    case (op)
      OP_R:           return fn;
      OP_BEQ, OP_BNE: return 3'd1;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] alu_src(input logic [2:0] op);
    return (op == OP_ADDI || op == OP_LW || op == OP_SW) ? 2'd1 : 2'd0;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= main_op;
        fn_q <= alu_in[2:0];
      end
      // Counts idle cycles while a RAM access is outstanding; zero everywhere else.
      if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
        wait_q <= wait_q + TIMEOUT_W'(1);
      else
        wait_q <= '0;
    end
  end

  // NOTE: every output and state_d gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    alu_out = 3'd0;
    alusrc  = 2'd0;
    en_pc   = 1'b0;
    jump    = 1'b0;
    pcsrc   = 1'b0;
    we_reg  = 1'b0;
    en_ram  = 1'b0;
    we_ram  = 1'b0;
    wrtsrc  = 1'b0;
    rdsrc   = 1'b0;
    ir_we   = 1'b0;
    halted  = 1'b0;
    trap    = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        en_ram = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        case (main_op)
          OP_HALT: state_d = S_HALT;
          OP_R:    state_d = (alu_in > 4'd5) ? S_TRAP : S_EXEC;
          OP_JMP: begin
            en_pc   = 1'b1;
            jump    = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_out = alu_code(op_q, fn_q);
        alusrc  = alu_src(op_q);
        case (op_q)
          OP_BEQ, OP_BNE: begin
            en_pc   = 1'b1;
            pcsrc   = (op_q == OP_BEQ) ? zero : ~zero;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        en_ram = 1'b1;
        rdsrc  = 1'b1;
        we_ram = (op_q == OP_SW);
        alusrc = 2'd1;
        if (mem_ready) begin
          en_pc   = (op_q == OP_SW);
          state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
        end else if (timed_out) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        we_reg  = 1'b1;
        wrtsrc  = (op_q == OP_LW);
        alu_out = alu_code(op_q, fn_q);
        alusrc  = alu_src(op_q);
        en_pc   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: trap   = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each instruction into
// its expected per-cycle strobe trace, which is replayed against the DUT.
module tb_multicycle_controller;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] main_op = '0;
  logic [3:0] alu_in = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_out;
  logic [1:0] alusrc;
  logic       en_pc, jump, pcsrc, we_reg, en_ram, we_ram, wrtsrc, rdsrc, ir_we, halted, trap;
  logic [2:0] state;

  multicycle_controller #(.TIMEOUT(TO), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .main_op(main_op), .alu_in(alu_in), .zero(zero),
    .mem_ready(mem_ready), .alu_out(alu_out), .alusrc(alusrc), .en_pc(en_pc), .jump(jump),
    .pcsrc(pcsrc), .we_reg(we_reg), .en_ram(en_ram), .we_ram(we_ram), .wrtsrc(wrtsrc),
    .rdsrc(rdsrc), .ir_we(ir_we), .halted(halted), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] alu;
    logic [1:0] asrc;
    logic en_pc, jump, pcsrc, we_reg, en_ram, we_ram, wrtsrc, rdsrc, ir_we, halted, trap;
  } outs_t;

  typedef struct {
    logic       rdy;
    logic [2:0] mop;
    logic [3:0] mfn;
    logic       z;
    outs_t      o;
  } step_t;

  step_t q[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t obs;
    obs = {state, alu_out, alusrc, en_pc, jump, pcsrc, we_reg, en_ram, we_ram, wrtsrc, rdsrc,
           ir_we, halted, trap};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic [2:0] mop, input logic [3:0] mfn,
                      input logic z, input outs_t o);
    step_t s;
    s.rdy = rdy; s.mop = mop; s.mfn = mfn; s.z = z; s.o = o;
    q.push_back(s);
  endtask

  // Terminal states: no strobes regardless of inputs, only the sticky flag.
  task automatic add_terminal(input logic [2:0] st);
    outs_t o;
    for (int i = 0; i < 20; i++) begin
      o = blank(st);
      o.halted = (st == 3'd6);
      o.trap   = (st == 3'd7);
      push(rbit(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), rbit(), o);
    end
  endtask

  // Expected trace of one instruction: ready after 'wait_f' / 'wait_m' idle cycles,
  // trapping once more than TO idle cycles would be needed.
  task automatic model_instr(input logic [2:0] op, input logic [3:0] fn, input logic z,
                             input int wait_f, input int wait_m, output bit terminal);
    outs_t o;
    logic  ready;
    logic [2:0] alu;
    logic [1:0] asrc;
    terminal = 1'b0;
    for (int i = 0; i <= wait_f && i <= TO; i++) begin
      ready = (i == wait_f);
      o = blank(3'd1); o.en_ram = 1'b1; o.ir_we = ready;
      push(ready, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), rbit(), o);
    end
    if (wait_f > TO) begin add_terminal(3'd7); terminal = 1'b1; return; end

    o = blank(3'd2);
    if (op == 3'd6) begin o.en_pc = 1'b1; o.jump = 1'b1; end
    push(rbit(), op, fn, rbit(), o);
    if (op == 3'd7) begin add_terminal(3'd6); terminal = 1'b1; return; end
    if (op == 3'd0 && fn > 4'd5) begin add_terminal(3'd7); terminal = 1'b1; return; end
    if (op == 3'd6) return;

    alu  = (op == 3'd0) ? fn[2:0] : (op == 3'd4 || op == 3'd5) ? 3'd1 : 3'd0;
    asrc = (op == 3'd1 || op == 3'd2 || op == 3'd3) ? 2'd1 : 2'd0;
    o = blank(3'd3); o.alu = alu; o.asrc = asrc;
    if (op == 3'd4 || op == 3'd5) begin
      o.en_pc = 1'b1;
      o.pcsrc = (op == 3'd4) ? z : !z;
      push(rbit(), op, fn, z, o);
      return;
    end
    push(rbit(), op, fn, rbit(), o);

    if (op == 3'd2 || op == 3'd3) begin
      for (int i = 0; i <= wait_m && i <= TO; i++) begin
        ready = (i == wait_m);
        o = blank(3'd4); o.en_ram = 1'b1; o.rdsrc = 1'b1; o.asrc = 2'd1;
        o.we_ram = (op == 3'd3);
        o.en_pc  = (op == 3'd3) && ready;
        push(ready, op, fn, rbit(), o);
      end
      if (wait_m > TO) begin add_terminal(3'd7); terminal = 1'b1; return; end
      if (op == 3'd3) return;
    end

    o = blank(3'd5); o.we_reg = 1'b1; o.wrtsrc = (op == 3'd2);
    o.alu = alu; o.asrc = asrc; o.en_pc = 1'b1;
    push(rbit(), op, fn, rbit(), o);
  endtask

  // Inputs change on the falling edge; outputs are compared 1 ns later.
  task automatic play(input string tag, input bit stop_in_mem);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      mem_ready = s.rdy; main_op = s.mop; alu_in = s.mfn; zero = s.z;
      #1;
      check(tag, s.o);
      if (stop_in_mem && s.o.st == 3'd4) begin
        q.delete();
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_outputs", blank(3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_after_release", blank(3'd0));
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [3:0] fn,
                     input logic z, input int wait_f, input int wait_m);
    bit terminal;
    model_instr(op, fn, z, wait_f, wait_m, terminal);
    play(tag, 1'b0);
    if (terminal) do_reset();
  endtask

  initial begin
    bit term;
    logic [2:0] rop;
    logic [3:0] rfn;
    int wf, wm;

    do_reset();
    run("r_funct3",    3'd0, 4'd3, 1'b0, 2, 0);
    run("lw",          3'd2, 4'd0, 1'b0, 1, 1);
    run("sw",          3'd3, 4'd0, 1'b0, 1, 1);
    run("beq_taken",   3'd4, 4'd0, 1'b1, 0, 0);
    run("bne_z1",      3'd5, 4'd0, 1'b1, 0, 0);
    run("beq_not",     3'd4, 4'd0, 1'b0, 0, 0);
    run("bne_z0",      3'd5, 4'd0, 1'b0, 0, 0);
    run("jmp",         3'd6, 4'd0, 1'b0, 0, 0);
    run("addi",        3'd1, 4'd7, 1'b0, 0, 0);
    run("fetch_edge",  3'd0, 4'd5, 1'b0, TO, 0);
    run("mem_edge",    3'd2, 4'd0, 1'b0, 0, TO);
    run("halt",        3'd7, 4'd0, 1'b0, 0, 0);
    run("illegal_fn",  3'd0, 4'd9, 1'b0, 0, 0);
    run("fetch_tmo",   3'd0, 4'd0, 1'b0, TO + 1, 0);
    run("mem_tmo",     3'd3, 4'd0, 1'b0, 0, TO + 1);

    model_instr(3'd3, 4'd0, 1'b0, 0, 2, term);
    play("sw_pre_reset", 1'b1);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_mem", blank(3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_after_mid_mem", blank(3'd0));

    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd7 && $urandom_range(0, 3) != 0) rop = 3'($urandom_range(0, 5));
      rfn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      wf  = ($urandom_range(0, 14) == 0) ? TO + 1 : int'($urandom_range(0, TO));
      wm  = ($urandom_range(0, 14) == 0) ? TO + 1 : int'($urandom_range(0, TO));
      run("random", rop, rfn, rbit(), wf, wm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
